tab_lookup_pipe: RTL
====================

Name: tab_lookup_pipe

Overview:
Parametrised, pipelined table-lookup operator for TDF stream graphs (e.g. JPEG decode Huffman/quant tables). Consumes an index stream, issues reads to a memory segment, returns looked-up values on an output stream. Allows up to DEPTH reads in flight with an internal return FIFO, unlike the single-outstanding two-state lookup. Forwards end-of-stream tokens in order after all prior lookups drain.

Parameters:
IDX_W, 8, index width
ADDR_W, 8, segment address width
DATA_W, 16, table data width
DEPTH, 4, max reads in flight plus buffered results (power of 2, >=2)
BASE, 0, address offset added to every index

Ports:
clock  in  1  clock
reset  in  1  reset, asynchronous, active-low
ind  in  IDX_W  index data
ind_e  in  1  index token is end-of-stream
ind_v  in  1  index token valid
ind_b  out  1  index backpressure
oval  out  DATA_W  looked-up value
oval_e  out  1  output token is end-of-stream
oval_v  out  1  output token valid
oval_b  in  1  output backpressure
segment_r_addr  out  ADDR_W  read address
segment_r_addr_e  out  1  always 0
segment_r_addr_v  out  1  read request valid
segment_r_addr_b  in  1  read request backpressure
segment_r_data  in  DATA_W  read data
segment_r_data_e  in  1  read data end flag (protocol error if set)
segment_r_data_v  in  1  read data valid
segment_r_data_b  out  1  read data backpressure
state  out  2  FSM state (RUN=0, DRAIN=1, EOS=2)
err  out  1  sticky protocol-error flag

Behaviour:
- Transfer on any stream = v && !b in same cycle.
- Reset (async, active-low): state=RUN, inflight=0, FIFO empty, err=0. Outputs: ind_b=1, oval_v=0, oval_e=0, segment_r_addr_v=0, segment_r_data_b=1, oval=0. Reset mid-operation discards all inflight reads and buffered data; late segment returns after reset are not tracked (segment must be reset together).
- inflight: reads issued, data not yet returned; cnt: FIFO occupancy. Invariant inflight+cnt <= DEPTH.
- RUN: if ind_v && !ind_e && !segment_r_addr_b && inflight+cnt < DEPTH: ind_b=0, segment_r_addr_v=1, segment_r_addr=(BASE+ind) truncated to ADDR_W (ind zero-extended), inflight++. Combinational issue, same cycle as index accept. Otherwise ind_b=1, addr_v=0.
- RUN, ind_v && ind_e: ind_b=1 (token held), go DRAIN.
- DRAIN: no issues; when inflight==0 && cnt==0 go EOS.
- EOS: oval_v=1, oval_e=1, oval=0; when !oval_b: ind_b=0 (consume eos token), go RUN. Exactly one eos out per eos in.
- Return path: segment_r_data_b=0 whenever inflight>0 (space guaranteed by credit rule); =1 when inflight==0. Accepted return: inflight--, data pushed to FIFO. If segment_r_data_e=1 on accepted return: err set sticky, beat still pushed (data as given) and counted.
- Output (RUN/DRAIN): oval_v = cnt>0, oval = FIFO head, oval_e=0; pop on !oval_b. FIFO is registered: data accepted in cycle t visible on oval at t+1 earliest. Minimum index-to-value latency = segment latency + 1.
- Simultaneous issue, return and pop in one cycle: all take effect; inflight and cnt update net (+1-1 etc.). Credit check uses pre-cycle values (no same-cycle credit recycling).
- Order preserved: segment returns in request order; FIFO is in-order.
- FIFO pointers wrap modulo DEPTH; full (cnt==DEPTH) unreachable with credit rule but must not corrupt if reached.
- Counters width clog2(DEPTH+1).

Test Plan:
- Single lookup, segment latency 1, BASE=0: ind=5 -> segment_r_addr=5 same cycle; return 0x1234 -> oval=0x1234, oval_v next cycle.
- Throughput: 8 back-to-back indices 0..7, segment latency 2, oval_b=0 -> one addr per cycle, 8 values in order, no bubbles after fill.
- Backpressure: oval_b=1 held, DEPTH=4, stream 6 indices -> exactly 4 issued, ind_b=1 thereafter; release oval_b -> remaining 2 issued, all 6 values in order.
- EOS ordering: indices 1,2 then eos with 3-cycle segment latency -> state DRAIN until both values out, then oval_e=1 one beat, state RUN, next index accepted.
- BASE=0xF0, ADDR_W=8, ind=0x20 -> segment_r_addr=0x10 (wrap); returned segment_r_data_e=1 -> err=1 stays set, value still output.
- Assert reset with 3 reads inflight and 1 buffered -> all outputs at reset values next edge, state=0, err=0; post-reset lookup ind=3 works normally.

Source files
------------

// File: rtl/tab_lookup_pipe.sv
// Pipelined table lookup: indices become segment reads, and up to DEPTH of them can be
// outstanding at once; results are returned in order through a small FIFO, and EOS is forwarded after the drain.
module tab_lookup_pipe #(
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int BASE   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  ind,
  input  logic              ind_e,
  input  logic              ind_v,
  output logic              ind_b,
  output logic [DATA_W-1:0] oval,
  output logic              oval_e,
  output logic              oval_v,
  input  logic              oval_b,
  output logic [ADDR_W-1:0] segment_r_addr,
  output logic              segment_r_addr_e,
  output logic              segment_r_addr_v,
  input  logic              segment_r_addr_b,
  input  logic [DATA_W-1:0] segment_r_data,
  input  logic              segment_r_data_e,
  input  logic              segment_r_data_v,
  output logic              segment_r_data_b,
  output logic [1:0]        state,
  output logic              err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, EOS = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     inflight_q, inflight_d, cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW:0]       used;
  logic              issue, ret, push, pop;

  always_comb begin
    state_d          = state_q;
    ind_b            = 1'b1;
    segment_r_addr_v = 1'b0;
    issue            = 1'b0;
    oval_v           = 1'b0;
    oval_e           = 1'b0;
    oval             = '0;
    pop              = 1'b0;
    // Credit check uses pre-cycle counts, so a slot freed this cycle is not reused until the next.
    used = {1'b0, inflight_q} + {1'b0, cnt_q};
    segment_r_addr = ADDR_W'(BASE) + ADDR_W'(ind);

    case (state_q)
      RUN: begin
        if (ind_v) begin
          if (ind_e) state_d = DRAIN;
          else if (!segment_r_addr_b && used < DEPTH_W) begin
            issue            = 1'b1;
            ind_b            = 1'b0;
            segment_r_addr_v = 1'b1;
          end
        end
      end
      DRAIN: if (inflight_q == '0 && cnt_q == '0) state_d = EOS;
      EOS: begin
        oval_v = 1'b1;
        oval_e = 1'b1;
        if (!oval_b) begin
          ind_b   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (state_q != EOS && cnt_q != '0) begin
      oval_v = 1'b1;
      oval   = mem_q[rd_ptr_q];
      pop    = !oval_b;
    end

    segment_r_data_b = (inflight_q == '0);
    ret  = segment_r_data_v && (inflight_q != '0);
    // A push into a full FIFO is dropped unless a pop makes room this same cycle.
    push = ret && (cnt_q != DEPTH_N || pop);

    inflight_d = inflight_q + CW'(issue) - CW'(ret);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    err_d      = err_q | (ret & segment_r_data_e);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= segment_r_data;
  end

  assign segment_r_addr_e = 1'b0;
  assign state            = state_q;
  assign err              = err_q;
endmodule
